// File: rtl/riscv_mem_arbiter.sv
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

// ============================================================================
//  Module   : riscv_mem_arbiter
//  Purpose  : Arbitrates one single-port memory between an instruction-fetch
//             port and a data port.
//             - Data has priority.
//             - A starve counter forces a fetch grant after STARVE_LIMIT
//               consecutive denied fetch cycles.
//             - Read responses return one cycle after the grant and are
//               routed back by a registered owner field.
//  Ports    : i_clk, i_rstn                      clock, async active-low reset
//             i_if_req/i_if_addr                 fetch request
//             o_if_gnt/o_if_rvalid/o_if_rdata    fetch grant and response
//             i_d_req/i_d_wr_en/i_d_addr         data request
//             i_d_wdata/i_d_byte_sel             data write payload
//             o_d_gnt/o_d_rvalid/o_d_rdata       data grant and response
//             o_mem_*                            memory request, to memory
//             i_mem_rdata                        memory read data (1-cycle latency)
//             o_starve_force                     fetch priority forced this cycle
//  Revision : 1.0  initial release
// ============================================================================
module riscv_mem_arbiter #(
  parameter int ADDR_BIT     = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_if_req,
  input  logic [`XLEN-1:0]    i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [`XLEN-1:0]    o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_wr_en,
  input  logic [`XLEN-1:0]    i_d_addr,
  input  logic [`XLEN-1:0]    i_d_wdata,
  input  logic [3:0]          i_d_byte_sel,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [`XLEN-1:0]    o_d_rdata,
  output logic                o_mem_en,
  output logic                o_mem_wr_en,
  output logic [ADDR_BIT-3:0] o_mem_addr,
  output logic [`XLEN-1:0]    o_mem_wdata,
  output logic [3:0]          o_mem_byte_sel,
  input  logic [`XLEN-1:0]    i_mem_rdata,
  output logic                o_starve_force
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t     r_owner;
  logic [3:0] r_starve_cnt;

  logic w_force;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_d_write;
  logic w_unused_addr_bits;

  // Address bits [1:0] and bits above ADDR_BIT never reach the memory.
  assign w_unused_addr_bits = ^{i_if_addr, i_d_addr};

  assign w_force = (r_starve_cnt == c_starve_limit);

  // Zero-latency grant logic. Reset gating keeps the memory idle while
  // i_rstn is low even if requesters keep their requests raised.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (i_rstn) begin
      if (w_force) begin
        w_if_gnt = i_if_req;
      end else begin
        w_d_gnt  = i_d_req;
        w_if_gnt = i_if_req & ~i_d_req;
      end
    end
  end

  assign w_d_write = w_d_gnt & i_d_wr_en;

  // Starve counter: counts consecutive cycles of denied fetch requests and
  // saturates at the limit; any idle or granted fetch cycle restarts it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_if_req || w_if_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt < c_starve_limit) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Owner of the read in flight; writes produce no response.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_owner <= OWN_NONE;
    end else if (w_if_gnt) begin
      r_owner <= OWN_IF;
    end else if (w_d_gnt && !i_d_wr_en) begin
      r_owner <= OWN_D;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  // Memory request mux.
  always_comb begin
    o_mem_addr = '0;
    if (w_if_gnt) begin
      o_mem_addr = i_if_addr[ADDR_BIT-1:2];
    end else if (w_d_gnt) begin
      o_mem_addr = i_d_addr[ADDR_BIT-1:2];
    end
  end

  assign o_if_gnt       = w_if_gnt;
  assign o_d_gnt        = w_d_gnt;
  assign o_starve_force = w_force & i_rstn;
  assign o_mem_en       = w_if_gnt | w_d_gnt;
  assign o_mem_wr_en    = w_d_write;
  assign o_mem_wdata    = w_d_write ? i_d_wdata    : '0;
  assign o_mem_byte_sel = w_d_write ? i_d_byte_sel : 4'd0;

  // Response routing; rdata is zero whenever its valid is low.
  assign o_if_rvalid = i_rstn & (r_owner == OWN_IF);
  assign o_d_rvalid  = i_rstn & (r_owner == OWN_D);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

// ============================================================================
//  Module   : tb_riscv_mem_arbiter
//  Purpose  : Self-checking bench for riscv_mem_arbiter.
//             - Grants and the memory request are checked in the request
//               cycle against a reference model.
//             - Expected read responses are queued and compared by an
//               independent response monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_mem_arbiter;

  localparam int ADDR_BIT     = 12;
  localparam int STARVE_LIMIT = 4;
  localparam int WORDS        = 1 << (ADDR_BIT - 2);

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                if_req = 1'b0;
  logic [`XLEN-1:0]    if_addr = '0;
  logic                if_gnt;
  logic                if_rvalid;
  logic [`XLEN-1:0]    if_rdata;
  logic                d_req = 1'b0;
  logic                d_wr_en = 1'b0;
  logic [`XLEN-1:0]    d_addr = '0;
  logic [`XLEN-1:0]    d_wdata = '0;
  logic [3:0]          d_byte_sel = '0;
  logic                d_gnt;
  logic                d_rvalid;
  logic [`XLEN-1:0]    d_rdata;
  logic                mem_en;
  logic                mem_wr_en;
  logic [ADDR_BIT-3:0] mem_addr;
  logic [`XLEN-1:0]    mem_wdata;
  logic [3:0]          mem_byte_sel;
  logic [`XLEN-1:0]    mem_rdata = '0;
  logic                starve_force;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(
    .ADDR_BIT     (ADDR_BIT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_if_req       (if_req),
    .i_if_addr      (if_addr),
    .o_if_gnt       (if_gnt),
    .o_if_rvalid    (if_rvalid),
    .o_if_rdata     (if_rdata),
    .i_d_req        (d_req),
    .i_d_wr_en      (d_wr_en),
    .i_d_addr       (d_addr),
    .i_d_wdata      (d_wdata),
    .i_d_byte_sel   (d_byte_sel),
    .o_d_gnt        (d_gnt),
    .o_d_rvalid     (d_rvalid),
    .o_d_rdata      (d_rdata),
    .o_mem_en       (mem_en),
    .o_mem_wr_en    (mem_wr_en),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_byte_sel (mem_byte_sel),
    .i_mem_rdata    (mem_rdata),
    .o_starve_force (starve_force)
  );

  // External RAM seen by the arbiter: one-cycle read latency, byte writes.
  logic [31:0] ram [WORDS];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_byte_sel[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model state.
  typedef struct packed {
    logic [1:0]  port;   // 0 none, 1 fetch, 2 data
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] shadow [WORDS];
  int          m_starve = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: each cycle pops the response owed by the previous cycle.
  always @(posedge clk) begin
    resp_t e;
    #1;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("if_rvalid", 32'(if_rvalid), 32'(e.port == 2'd1));
    chk("d_rvalid",  32'(d_rvalid),  32'(e.port == 2'd2));
    chk("if_rdata",  if_rdata, (e.port == 2'd1) ? e.data : 32'h0);
    chk("d_rdata",   d_rdata,  (e.port == 2'd2) ? e.data : 32'h0);
  end

  // One request cycle: drive, check the request-side outputs against the
  // model, and queue the expected response for the monitor.
  task automatic cyc(input logic ifr, input logic [31:0] ifa,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dwd, input logic [3:0] bs);
    logic  frc, eg, edg, wr;
    int    wi, wd;
    resp_t e;
    @(posedge clk);
    #2;
    if_req = ifr; if_addr = ifa;
    d_req = dr; d_wr_en = dw; d_addr = da; d_wdata = dwd; d_byte_sel = bs;
    #2;
    frc = (m_starve == STARVE_LIMIT);
    eg  = frc ? ifr : (ifr && !dr);
    edg = frc ? 1'b0 : dr;
    wr  = edg && dw;
    wi  = int'(ifa[31:2]) % WORDS;
    wd  = int'(da[31:2]) % WORDS;
    chk("if_gnt",       32'(if_gnt),       32'(eg));
    chk("d_gnt",        32'(d_gnt),        32'(edg));
    chk("starve_force", 32'(starve_force), 32'(frc));
    chk("mem_en",       32'(mem_en),       32'(eg || edg));
    if (eg || edg) chk("mem_addr", 32'(mem_addr), 32'(eg ? wi : wd));
    chk("mem_wr_en",    32'(mem_wr_en),    32'(wr));
    chk("mem_wdata",    mem_wdata,         wr ? dwd : 32'h0);
    chk("mem_byte_sel", 32'(mem_byte_sel), wr ? 32'(bs) : 32'h0);
    e.port = eg ? 2'd1 : (edg && !dw) ? 2'd2 : 2'd0;
    e.data = (e.port == 2'd1) ? shadow[wi] : (e.port == 2'd2) ? shadow[wd] : 32'h0;
    exp_q.push_back(e);
    if (wr)
      for (int b = 0; b < 4; b++)
        if (bs[b]) shadow[wd][8*b +: 8] = dwd[8*b +: 8];
    if (!ifr || eg) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst if_gnt",       32'(if_gnt),       32'h0);
    chk("rst d_gnt",        32'(d_gnt),        32'h0);
    chk("rst mem_en",       32'(mem_en),       32'h0);
    chk("rst mem_wr_en",    32'(mem_wr_en),    32'h0);
    chk("rst starve_force", 32'(starve_force), 32'h0);
    chk("rst if_rvalid",    32'(if_rvalid),    32'h0);
    chk("rst d_rvalid",     32'(d_rvalid),     32'h0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]    = 32'h9E37_79B1 * (i + 1);
      shadow[i] = 32'h9E37_79B1 * (i + 1);
    end

    // Reset state, with every request raised to prove the gating.
    if_req = 1'b1; d_req = 1'b1; d_wr_en = 1'b1; d_byte_sel = 4'hF;
    #23;
    chk_reset_outputs();
    @(posedge clk); #2;
    if_req = 1'b0; d_req = 1'b0; d_wr_en = 1'b0; d_byte_sel = 4'h0;
    rstn = 1'b1;

    // Lone fetch at 0x10 -> word 4.
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle();
    // Fetch and data read together -> data wins, word 8.
    cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    idle();
    // Partial write then read it back through both ports.
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 32'hDEAD_BEEF, 4'b0011);
    idle();
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_F047, 32'h0, 4'h0);
    idle();
    // Starvation: both held; fetch forced on the fifth cycle.
    repeat (7) cyc(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    idle();
    // Alternating fetch / data reads back-to-back.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      else            cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'(i * 4 + 32'h200), 32'h0, 4'h0);
    end
    idle();

    // Randomised traffic, including high and low address bits.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom(),
          $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom(),
          $urandom(), 4'($urandom_range(0, 15)));
    end
    idle();

    // Outstanding fetch read killed by reset.
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    rstn = 1'b0;
    void'(exp_q.pop_back());
    m_starve = 0;
    d_req = 1'b1; d_wr_en = 1'b1; d_byte_sel = 4'hF;
    #1;
    chk_reset_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #2;
    if_req = 1'b0; d_req = 1'b0; d_wr_en = 1'b0; d_byte_sel = 4'h0;
    rstn = 1'b1;
    // Counter must restart from zero: force again on the fifth cycle.
    repeat (6) cyc(1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    idle();
    idle();

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk); #3;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
